conv_window_ctrl: RTL
=====================

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter KERN_DIM, default 3, kernel side length in pixels.
REQ-002 SHALL have parameter IMG_W, default 28, image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 28, image height in pixels.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a frame.
REQ-007 SHALL have port reuse_w  input  1  sampled with start; 1 = skip weight load.
REQ-008 SHALL have port w_valid  input  1  weight word present on datapath.
REQ-009 SHALL have port pix_valid  input  1  pixel present on datapath.
REQ-010 SHALL have port pix_ready  output  1  controller accepts pixel this cycle.
REQ-011 SHALL have port write_weights  output  1  datapath writes weight at w_addr.
REQ-012 SHALL have port w_addr  output  $clog2(KERN_DIM*KERN_DIM)  weight index.
REQ-013 SHALL have port shift_en  output  1  datapath shifts line buffer one pixel.
REQ-014 SHALL have port win_valid  output  1  current window is a legal convolution output.
REQ-015 SHALL have ports busy and done  output  1 each  frame in progress; one-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement states IDLE, LOAD_W, PRIME, RUN, DONE.
REQ-017 IDLE: start=1 SHALL go to PRIME if reuse_w=1, else LOAD_W; start outside IDLE SHALL be ignored.
REQ-018 LOAD_W: write_weights SHALL equal w_valid combinationally; w_addr SHALL increment per accepted word, 0..KERN_DIM*KERN_DIM-1; after the last word the state SHALL go to PRIME and w_addr SHALL return to 0.
REQ-019 w_valid outside LOAD_W SHALL be ignored (write_weights=0).
REQ-020 PRIME and RUN: pix_ready SHALL be 1; shift_en SHALL equal pix_valid&pix_ready combinationally; pix_valid=0 SHALL stall all counters.
REQ-021 Column counter (0..IMG_W-1) and row counter (0..IMG_H-1) SHALL advance per accepted pixel, column wrapping to 0 and incrementing row.
REQ-022 PRIME SHALL accept (KERN_DIM-1)*IMG_W+KERN_DIM-1 pixels, then go to RUN.
REQ-023 win_valid SHALL assert exactly one cycle after acceptance of pixel (r,c) with r>=KERN_DIM-1 and c>=KERN_DIM-1; wrap-around columns c<KERN_DIM-1 SHALL produce win_valid=0.
REQ-024 Per frame win_valid SHALL pulse exactly (IMG_H-KERN_DIM+1)*(IMG_W-KERN_DIM+1) times.
REQ-025 Acceptance of pixel (IMG_H-1,IMG_W-1) SHALL go to DONE; DONE SHALL assert done for one cycle, then go to IDLE.
REQ-026 busy SHALL be 1 in all states except IDLE.
REQ-027 KERN_DIM>IMG_W or KERN_DIM>IMG_H SHALL be a compile-time error.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, counters and w_addr to 0, all outputs 0.
REQ-029 reset mid-frame SHALL abandon the frame without done; next frame needs a new start.

Configuration
REQ-030 With FRAME_CNT_EN defined, SHALL add output frame_cnt, 16 bits, reset 0, incremented on each done, wrapping at 65535 to 0.
REQ-031 Without FRAME_CNT_EN, frame_cnt SHALL not exist and behaviour is otherwise identical.

Structure
REQ-032 State encoding localparams and the output-count function SHALL live in shared package conv_pkg.
REQ-033 Row/column position tracking SHALL be sub-module conv_pos_cnt (enable, wrap, row/col outputs).

Verification (KERN_DIM=3, IMG_W=IMG_H=5)
REQ-034 Reset then start, reuse_w=0, 9 w_valid -> write_weights 9 cycles, w_addr 0..8, state PRIME.
REQ-035 25 back-to-back pixels -> first win_valid after pixel 13, 9 win_valid pulses total, none after columns 0/1, done one cycle after last.
REQ-036 pix_valid toggling 1/0 -> same 9 pulses, shift_en only on valid cycles, counters frozen during gaps.
REQ-037 Second frame start with reuse_w=1 -> no write_weights, PRIME entered next cycle; start during RUN ignored.
REQ-038 reset asserted after pixel 15 -> all outputs 0 immediately, IDLE, no done; FRAME_CNT_EN: frame_cnt 1 after first frame, unchanged by aborted frame.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared state encoding and sizing helpers for the convolution window controller.
package conv_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_W = 3'd1;
   localparam logic [2:0] ST_PRIME  = 3'd2;
   localparam logic [2:0] ST_RUN    = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      LOAD_W = ST_LOAD_W,
      PRIME  = ST_PRIME,
      RUN    = ST_RUN,
      DONE   = ST_DONE
   } conv_state_e;

   // Legal output windows produced by one frame.
   function automatic int win_count(input int kern_dim, input int img_w, input int img_h);
      return (img_h - kern_dim + 32'sd1) * (img_w - kern_dim + 32'sd1);
   endfunction

   // Counter width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n > 32'sd1) ? $clog2(n) : 32'sd1;
   endfunction

endpackage

// File: rtl/conv_pos_cnt.sv
// Raster row/column tracker; o_wrap flags the final pixel position of the frame.
module conv_pos_cnt
   import conv_pkg::*;
#(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int COL_W = clog2_min1(IMG_W),
   parameter int ROW_W = clog2_min1(IMG_H)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [COL_W-1:0] o_col,
   output logic [ROW_W-1:0] o_row,
   output logic             o_wrap
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             w_col_end;
   logic             w_row_end;

   assign w_col_end = (r_col == COL_LAST);
   assign w_row_end = (r_row == ROW_LAST);

   // Column steps per enabled cycle; row steps on column wrap, both wrap at frame end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_clr) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_en) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + ROW_W'(1'b1);
         end else begin
            r_col <= r_col + COL_W'(1'b1);
         end
      end
   end

   assign o_col  = r_col;
   assign o_row  = r_row;
   assign o_wrap = w_col_end && w_row_end;

endmodule

// File: rtl/conv_window_ctrl.sv
// Convolution window controller: weight load, line-buffer priming and window-valid strobes.
// Optional feature: define FRAME_CNT_EN to add the 16-bit completed-frame counter output frame_cnt.
module conv_window_ctrl
   import conv_pkg::*;
#(
   parameter int KERN_DIM = 3,
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28,
   localparam int WA_W    = clog2_min1(KERN_DIM * KERN_DIM)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            reuse_w,
   input  logic            w_valid,
   input  logic            pix_valid,
   output logic            pix_ready,
   output logic            write_weights,
   output logic [WA_W-1:0] w_addr,
   output logic            shift_en,
   output logic            win_valid,
   output logic            busy,
`ifdef FRAME_CNT_EN
   output logic [15:0]     frame_cnt,
`endif
   output logic            done
);

   localparam int COL_W = clog2_min1(IMG_W);
   localparam int ROW_W = clog2_min1(IMG_H);
   localparam logic [WA_W-1:0]  W_LAST    = WA_W'(KERN_DIM * KERN_DIM - 1);
   localparam logic [COL_W-1:0] WIN_COL0  = COL_W'(KERN_DIM - 1);
   localparam logic [ROW_W-1:0] WIN_ROW0  = ROW_W'(KERN_DIM - 1);
   // Priming ends on pixel (KERN_DIM-1, KERN_DIM-2); a 1x1 kernel needs no priming at all.
   localparam logic [COL_W-1:0] PRIME_COL = COL_W'((KERN_DIM > 1) ? KERN_DIM - 2 : 0);
   localparam bit               PRIME_EMPTY = (KERN_DIM == 1);

   if (KERN_DIM < 1 || KERN_DIM > IMG_W || KERN_DIM > IMG_H) begin : g_bad_geometry
      $error("conv_window_ctrl: KERN_DIM must lie in 1..min(IMG_W, IMG_H)");
   end

   conv_state_e      r_state;
   conv_state_e      w_next;
   logic [WA_W-1:0]  r_w_addr;
   logic             r_win_valid;
   logic             w_pix_phase;
   logic             w_accept;
   logic             w_win_pos;
   logic             w_prime_end;
   logic             w_frame_end;
   logic [COL_W-1:0] w_col;
   logic [ROW_W-1:0] w_row;

   assign w_pix_phase = (r_state == PRIME) || (r_state == RUN);
   assign w_accept    = pix_valid && w_pix_phase;
   assign w_win_pos   = (w_row >= WIN_ROW0) && (w_col >= WIN_COL0);
   assign w_prime_end = (w_row == WIN_ROW0) && (w_col == PRIME_COL);

   conv_pos_cnt #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
   ) u_pos (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (r_state == IDLE),
      .i_en   (w_accept),
      .o_col  (w_col),
      .o_row  (w_row),
      .o_wrap (w_frame_end)
   );

   // Next-state selection and the weight write strobe.
   always_comb begin
      w_next        = r_state;
      write_weights = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_next = reuse_w ? PRIME : LOAD_W;
            else       w_next = IDLE;
         end
         LOAD_W: begin
            write_weights = w_valid;
            if (w_valid && (r_w_addr == W_LAST)) w_next = PRIME;
            else                                 w_next = LOAD_W;
         end
         PRIME: begin
            if (w_accept && w_frame_end)                       w_next = DONE;
            else if (PRIME_EMPTY || (w_accept && w_prime_end)) w_next = RUN;
            else                                               w_next = PRIME;
         end
         RUN: begin
            if (w_accept && w_frame_end) w_next = DONE;
            else                         w_next = RUN;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register and weight address, which wraps back to 0 after the last word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_w_addr <= '0;
      end else begin
         r_state <= w_next;
         if (write_weights) r_w_addr <= (r_w_addr == W_LAST) ? '0 : r_w_addr + WA_W'(1'b1);
      end
   end

   // A window is valid the cycle after its bottom-right pixel is accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_win_valid <= 1'b0;
      else        r_win_valid <= w_accept && w_win_pos;
   end

`ifdef FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Completed frames, wrapping naturally at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                r_frame_cnt <= 16'd0;
      else if (r_state == DONE)  r_frame_cnt <= r_frame_cnt + 16'd1;
   end

   assign frame_cnt = r_frame_cnt;
`endif

   assign pix_ready = w_pix_phase;
   assign shift_en  = w_accept;
   assign w_addr    = r_w_addr;
   assign win_valid = r_win_valid;
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);

endmodule
